// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package rf_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

   localparam int RF_MAX_NRD = 4;

   // Address width for n entries; returns at least 1 so a 2-entry file still has an address bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write port, packed read ports and busy flag between the core and the register file.
interface regfile_mp_if
   import rf_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
);
   localparam int AW = clog2(NREGS);

   logic                  busy;
   logic                  we;
   logic [AW-1:0]         waddr;
   logic [XLEN-1:0]       wdata;
   logic [NRD*AW-1:0]     raddr;
   logic [NRD*XLEN-1:0]   rdata;

   modport master (input busy, rdata, output we, waddr, wdata, raddr);
   modport slave  (output busy, rdata, input we, waddr, wdata, raddr);
endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: range/zero checks, write bypass and entry mux.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int  XLEN     = 32,
   parameter int  NREGS    = 32,
   parameter bit  ZERO_REG = 1'b1,
   parameter bit  BYPASS   = 1'b1,
   localparam int AW       = clog2(NREGS)
) (
   input  logic            busy_i,
   input  logic [AW-1:0]   raddr_i,
   input  logic            wr_en_i,   // already qualified as a legal write
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] regs_i [NREGS],
   output logic [XLEN-1:0] rdata_o
);
   localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

   logic in_range;
   assign in_range = ({1'b0, raddr_i} < NREGS_W);

   // NOTE: rdata_o gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      rdata_o = '0;
      if (busy_i || !in_range) begin
         rdata_o = '0;
      end else if (ZERO_REG && raddr_i == '0) begin
         rdata_o = '0;
      end else if (BYPASS && wr_en_i && waddr_i == raddr_i) begin
         rdata_o = wdata_i;
      end else begin
         rdata_o = regs_i[raddr_i];
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: storage array, write port, post-reset clear sequencer, NRD read ports.
module regfile_mp
   import rf_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave rf
);
   localparam int          AW       = clog2(NREGS);
   localparam logic [AW:0] NREGS_W  = (AW+1)'(NREGS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   if (NRD < 1 || NRD > RF_MAX_NRD) begin : g_bad_nrd
      $error("regfile_mp: NRD out of range");
   end

   rf_state_e           state_q, state_d;
   logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
   logic                clr_we;
   logic                busy;
   logic                wr_legal;
   logic [XLEN-1:0]     mem_q [NREGS];
   logic [NRD*XLEN-1:0] rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_IDX) state_d = READY;
         end
         READY:   state_d = READY;
         default: state_d = CLEAR;
      endcase
   end

   assign busy     = (state_q == CLEAR);
   assign wr_legal = rf.we && (state_q == READY)
                     && ({1'b0, rf.waddr} < NREGS_W)
                     && !(ZERO_REG && rf.waddr == '0);

   // NOTE: the array has no reset branch; the clear sequencer zeroes it one entry per cycle instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we)        mem_q[clr_cnt_q] <= '0;
         else if (wr_legal) mem_q[rf.waddr]  <= rf.wdata;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      rf_read_port #(
         .XLEN     (XLEN),
         .NREGS    (NREGS),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .busy_i  (busy),
         .raddr_i (rf.raddr[i*AW +: AW]),
         .wr_en_i (wr_legal),
         .waddr_i (rf.waddr),
         .wdata_i (rf.wdata),
         .regs_i  (mem_q),
         .rdata_o (rdata[i*XLEN +: XLEN])
      );
   end

   assign rf.busy  = busy;
   assign rf.rdata = rdata;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the single-cycle RISC-V core. It replaces the fixed 32×32, two-read-port file with configurable width, depth and read-port count. It adds a hardwired zero register, write-to-read bypass, and a hardware clear sequencer that zeroes every entry after reset. The decode stage reads operands here, and the writeback stage drives the single write port.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (2..64; need not be a power of two)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- AW (derived, localparam) = clog2(NREGS)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous and active-high
- busy  out  1  high while clear sequence runs; writes ignored, reads return 0
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- raddr  in  NRD*AW  packed read addresses; port i at [i*AW +: AW]
- rdata  out  NRD*XLEN  packed read data; port i at [i*XLEN +: XLEN]

## Operation
- FSM states: CLEAR, READY. Clear counter clr_cnt is AW bits wide.
- rst high at a rising edge: state ← CLEAR, clr_cnt ← 0, busy ← 1. This holds for every edge while rst stays high, and no array entry is written.
- CLEAR with rst low: at each edge, entry[clr_cnt] ← 0 and clr_cnt increments. At the edge that clears entry NREGS-1, state ← READY and busy ← 0.
- rst reasserted during CLEAR: the counter restarts at 0, with no partial-state carry-over.
- READY: at an edge with we=1, entry[waddr] ← wdata. The write is dropped when waddr ≥ NREGS, or when waddr=0 and ZERO_REG=1.
- we during CLEAR or rst is ignored. The requester must wait for busy=0; no backpressure is provided.
- Reads are combinational, evaluated per port i in priority order:
  1. busy=1 → 0
  2. raddr_i ≥ NREGS → 0
  3. ZERO_REG and raddr_i=0 → 0
  4. BYPASS and we and waddr=raddr_i and the write is legal → wdata
  5. otherwise entry[raddr_i]
- Several read ports may address the same register; each receives identical data.
- Array contents before the first reset are undefined. Reading them before reset is a bench error, not a design error.

## Timing
- Reset values: busy=1, state=CLEAR, clr_cnt=0. rdata is all-zero for as long as busy=1.
- Clear latency: busy falls exactly NREGS rising edges after the first edge sampling rst=0.
  - Default parameters: 32 cycles.
- Write latency: the value is visible via the array on the cycle after the write edge.
- With BYPASS=1, the value is also visible combinationally in the write cycle itself.
- BYPASS=0: a read in the write cycle returns the old value.
- Read path has no registers; the combinational depth is one address compare plus one NREGS:1 mux per port.

## Structure
- Shared package rf_pkg:
  - state enum {CLEAR, READY}
  - clog2 function for AW
  - RF_MAX_NRD=4 constant
- One natural sub-module, rf_read_port: address decode, range/zero check, bypass compare and output mux.
  - Generated NRD times from the top level.
- The array, write logic and clear FSM stay in regfile_mp.

## Test plan
- Reset with defaults: rst high for 3 cycles then low → busy=1 for exactly 32 cycles, then busy=0; all 32 registers read back 0.
- Write/read: write x5=0xDEADBEEF, then read ports 0/1 at x5/x6 → 0xDEADBEEF / 0x00000000. A write to x0 of 0x1234 reads back 0 with ZERO_REG=1, and reads 0x1234 with ZERO_REG=0.
- Bypass: same cycle we=1, waddr=9, wdata=0x20, raddr0=9 → rdata0=0x20 combinationally when BYPASS=1. With BYPASS=0 it returns the prior value (0 after clear).
- Reset mid-clear: rst pulsed 1 cycle at clear cycle 10 → busy stays high for 32 cycles after the pulse. A we=1 issued during clear is dropped: register still 0.
- Parameter sweep, NREGS=24, NRD=3, XLEN=64:
  - clear lasts 24 cycles;
  - a write to addr 30 is dropped, and a read of 30 returns 0;
  - 3 ports reading the same addr 7 after writing 0x0123456789ABCDEF all return that value.
- Random regression against a reference array model: 10k cycles of random we/waddr/wdata/raddr, including same-address collisions → no mismatches.
